sysex_engine: RTL

- Single-clock, parametrised successor to the synth controller's sysex handler.
- Parses a raw MIDI byte stream for educational-ID (0x7D) sysex frames addressed to `midi_ch`.
- Performs parameter writes, bank loads and multi-bank patch loads into the synth register file.
- Streams patch dumps out through a valid/ready byte interface; no negedge clocking.

---
 rtl/sysex_engine.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sysex_engine.sv
// sysex_engine: parses educational-ID (0x7D) sysex frames into register writes, bank/patch loads and patch dumps.
// Optional macro SYSEX_CHECKSUM_EN adds a 7-bit checksum after load data and before the dump's closing F7.
module sysex_engine #(
  parameter int BANK_W      = 3,
  parameter int ADDR_W      = 7,
  parameter int BANK_DEPTH  = 64,
  parameter int PATCH_BANKS = 4,
  parameter logic [BANK_W*PATCH_BANKS-1:0] PATCH_BANK_MAP = 12'b101_010_001_000
) (
  input  logic              reg_clk,
  input  logic              reset_reg_N,
  input  logic [3:0]        midi_ch,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              dump_req,
  output logic              wr_en,
  output logic [BANK_W-1:0] wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [BANK_W-1:0] rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              err
);
  localparam int PIDX_W = $clog2(PATCH_BANKS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);
  localparam logic [PIDX_W-1:0] LAST_PIDX = PIDX_W'(PATCH_BANKS - 1);

  typedef enum logic [2:0] {R_IDLE, R_MFR, R_CMD, R_CTRL, R_BANK, R_PATCH, R_SKIP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_HDR, T_RD, T_DATA, T_END} tx_state_t;

  function automatic logic [BANK_W-1:0] map_bank(input logic [PIDX_W-1:0] idx);
    return PATCH_BANK_MAP[BANK_W*idx +: BANK_W];
  endfunction

  rx_state_t         rx_q;
  tx_state_t         tx_q;
  logic [2:0]        cnt_q;
  logic [BANK_W-1:0] c_bank_q, ld_bank_q;
  logic [ADDR_W-1:0] c_addr_q, addr_q;
  logic [7:0]        c_data_q;
  logic [PIDX_W-1:0] pidx_q;
  logic              full_q, dump_pend_q, err_q;
  logic              wr_en_q;
  logic [BANK_W-1:0] wr_bank_q, rd_bank_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q, t_addr_q;
  logic [7:0]        wr_data_q, tx_data_q;
  logic [PIDX_W-1:0] t_pidx_q;
  logic [1:0]        hdr_q;
  logic              rd_wait_q, tx_valid_q;
`ifdef SYSEX_CHECKSUM_EN
  logic [6:0]        sum_q, t_sum_q;
  logic              cks_seen_q, cks_sent_q;
`endif

  logic byte_v, is_f0, is_f7, tx_start, start_err;
  assign byte_v    = rx_valid && (rx_data < 8'hF8);  // realtime bytes never reach the parser
  assign is_f0     = byte_v && (rx_data == 8'hF0);
  assign is_f7     = byte_v && (rx_data == 8'hF7);
  assign tx_start  = dump_req || (is_f7 && dump_pend_q);
  assign start_err = tx_start && (tx_q != T_IDLE);

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      rx_q <= R_IDLE;       cnt_q <= '0;       c_bank_q <= '0;    c_addr_q <= '0;
      c_data_q <= '0;       ld_bank_q <= '0;   addr_q <= '0;      pidx_q <= '0;
      full_q <= 1'b0;       dump_pend_q <= 1'b0; err_q <= 1'b0;
      wr_en_q <= 1'b0;      wr_bank_q <= '0;   wr_addr_q <= '0;   wr_data_q <= '0;
`ifdef SYSEX_CHECKSUM_EN
      sum_q <= '0;          cks_seen_q <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      if (is_f0) begin
        rx_q <= R_MFR;      cnt_q <= '0;       addr_q <= '0;      pidx_q <= '0;
        full_q <= 1'b0;     dump_pend_q <= 1'b0; err_q <= 1'b0;
`ifdef SYSEX_CHECKSUM_EN
        sum_q <= '0;        cks_seen_q <= 1'b0;
`endif
      end else if (is_f7) begin
        rx_q        <= R_IDLE;
        dump_pend_q <= 1'b0;
        if (rx_q == R_CTRL) begin
          if (cnt_q == 3'd3) begin
            wr_en_q   <= 1'b1;
            wr_bank_q <= c_bank_q;
            wr_addr_q <= c_addr_q;
            wr_data_q <= c_data_q;
          end else begin
            err_q <= 1'b1;
          end
        end
`ifdef SYSEX_CHECKSUM_EN
        if ((rx_q == R_BANK || rx_q == R_PATCH) && !cks_seen_q) err_q <= 1'b1;
`endif
      end else if (byte_v && rx_data[7]) begin
        if (rx_q != R_IDLE && rx_data < 8'hF0) begin
          rx_q        <= R_IDLE;
          dump_pend_q <= 1'b0;
          err_q       <= 1'b1;
        end
      end else if (byte_v) begin
        case (rx_q)
          R_MFR: rx_q <= (rx_data == 8'h7D) ? R_CMD : R_SKIP;
          R_CMD: begin
            rx_q <= R_SKIP;
            if (rx_data[3:0] == midi_ch) begin
              case (rx_data[6:4])
                3'd1:    rx_q <= R_CTRL;
                3'd2:    rx_q <= R_BANK;
                3'd7:    rx_q <= R_PATCH;
                3'd3:    dump_pend_q <= 1'b1;
                default: ;
              endcase
            end
          end
          R_CTRL: begin
            case (cnt_q)
              3'd0:    c_bank_q <= rx_data[BANK_W-1:0];
              3'd1:    c_addr_q <= rx_data[ADDR_W-1:0];
              3'd2:    c_data_q <= rx_data;
              default: ;
            endcase
            if (cnt_q != 3'd4) cnt_q <= cnt_q + 3'd1;
          end
          R_BANK, R_PATCH: begin
            if (rx_q == R_BANK && cnt_q == 3'd0) begin
              ld_bank_q <= rx_data[BANK_W-1:0];
              cnt_q     <= 3'd1;
            end else if (!full_q) begin
              wr_en_q   <= 1'b1;
              wr_bank_q <= (rx_q == R_BANK) ? ld_bank_q : map_bank(pidx_q);
              wr_addr_q <= addr_q;
              wr_data_q <= rx_data;
`ifdef SYSEX_CHECKSUM_EN
              sum_q     <= sum_q + rx_data[6:0];
`endif
              if (addr_q == LAST_ADDR) begin
                addr_q <= '0;
                pidx_q <= pidx_q + 1'b1;
                if (rx_q == R_BANK || pidx_q == LAST_PIDX) full_q <= 1'b1;
              end else begin
                addr_q <= addr_q + 1'b1;
              end
            end
`ifdef SYSEX_CHECKSUM_EN
            else if (!cks_seen_q) begin
              cks_seen_q <= 1'b1;
              if (rx_data[6:0] != (7'd0 - sum_q)) err_q <= 1'b1;
            end
`endif
            else begin
              err_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (start_err) err_q <= 1'b1;
    end
  end

  // Each data byte takes one T_RD cycle for the address, one for rd_data, then waits in T_DATA for acceptance.
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      tx_q <= T_IDLE;     tx_valid_q <= 1'b0;  tx_data_q <= '0;  hdr_q <= '0;
      rd_bank_q <= '0;    rd_addr_q <= '0;     t_addr_q <= '0;   t_pidx_q <= '0;
      rd_wait_q <= 1'b0;
`ifdef SYSEX_CHECKSUM_EN
      t_sum_q <= '0;      cks_sent_q <= 1'b0;
`endif
    end else begin
      case (tx_q)
        T_IDLE: if (tx_start) begin
          tx_q       <= T_HDR;
          tx_valid_q <= 1'b1;
          tx_data_q  <= 8'hF0;
          hdr_q      <= '0;
          t_addr_q   <= '0;
          t_pidx_q   <= '0;
`ifdef SYSEX_CHECKSUM_EN
          t_sum_q    <= '0;
          cks_sent_q <= 1'b0;
`endif
        end
        T_HDR: if (tx_ready) begin
          hdr_q <= hdr_q + 2'd1;
          case (hdr_q)
            2'd0:    tx_data_q <= 8'h7D;
            2'd1:    tx_data_q <= {4'h7, midi_ch};
            default: begin
              tx_q       <= T_RD;
              tx_valid_q <= 1'b0;
              rd_bank_q  <= map_bank('0);
              rd_addr_q  <= '0;
              rd_wait_q  <= 1'b1;
            end
          endcase
        end
        T_RD: begin
          if (rd_wait_q) begin
            rd_wait_q <= 1'b0;
          end else begin
            tx_q       <= T_DATA;
            tx_valid_q <= 1'b1;
            tx_data_q  <= rd_data;
`ifdef SYSEX_CHECKSUM_EN
            t_sum_q    <= t_sum_q + rd_data[6:0];
`endif
          end
        end
        T_DATA: if (tx_ready) begin
          if (t_addr_q == LAST_ADDR && t_pidx_q == LAST_PIDX) begin
            tx_q <= T_END;
`ifdef SYSEX_CHECKSUM_EN
            tx_data_q <= {1'b0, 7'd0 - t_sum_q};
`else
            tx_data_q <= 8'hF7;
`endif
          end else begin
            tx_q       <= T_RD;
            tx_valid_q <= 1'b0;
            rd_wait_q  <= 1'b1;
            if (t_addr_q == LAST_ADDR) begin
              t_addr_q  <= '0;
              t_pidx_q  <= t_pidx_q + 1'b1;
              rd_addr_q <= '0;
              rd_bank_q <= map_bank(t_pidx_q + 1'b1);
            end else begin
              t_addr_q  <= t_addr_q + 1'b1;
              rd_addr_q <= t_addr_q + 1'b1;
            end
          end
        end
        T_END: if (tx_ready) begin
`ifdef SYSEX_CHECKSUM_EN
          if (!cks_sent_q) begin
            cks_sent_q <= 1'b1;
            tx_data_q  <= 8'hF7;
          end else
`endif
          begin
            tx_q       <= T_IDLE;
            tx_valid_q <= 1'b0;
          end
        end
        default: tx_q <= T_IDLE;
      endcase
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_bank  = wr_bank_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_bank  = rd_bank_q;
  assign rd_addr  = rd_addr_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign err      = err_q;
  assign busy     = (rx_q == R_BANK) || (rx_q == R_PATCH) || (tx_q != T_IDLE);
endmodule
